// File: rtl/mem_access_stage_pkg.sv
// Shared constants, types and helpers for the MEM pipeline stage.
// Build option MEM_MISALIGN_CHECK_EN enables the misaligned-access trap in the top.
package mem_access_stage_pkg;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    // funct3 encodings: [1:0] selects access size, [2] selects zero-extension on loads
    localparam logic [1:0]  F3SizeByte    = 2'b00;
    localparam logic [1:0]  F3SizeHalf    = 2'b01;
    localparam logic [1:0]  F3SizeWord    = 2'b10;
    localparam int unsigned F3UnsignedBit = 2;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Position of the MEM request in the pipeline-wide stall mask
    localparam int unsigned StallMemBit = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StXfer = 2'd1,
        StDone = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2
    } mem_size_e;

    function automatic mem_size_e decode_size(input logic [1:0] f3_size);
        mem_size_e size;
        case (f3_size)
            F3SizeByte: size = SizeByte;
            F3SizeHalf: size = SizeHalf;
            default:    size = SizeWord;
        endcase
        return size;
    endfunction

    function automatic logic [2:0] size_bytes(input mem_size_e size);
        logic [2:0] n;
        case (size)
            SizeByte: n = 3'd1;
            SizeHalf: n = 3'd2;
            default:  n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SizeHalf: mis = addr_lo[0];
            SizeWord: mis = (addr_lo != 2'b00);
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Combinational load result formatter: picks the loaded bytes from the assembly
// buffer and sign- or zero-extends them to the register width.
module mem_access_stage_load_extend
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     i_buf,
    input  mem_size_e       i_size,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_val
);

    logic w_sign_b;
    logic w_sign_h;

    assign w_sign_b = ~i_unsigned & i_buf[7];
    assign w_sign_h = ~i_unsigned & i_buf[15];

    always_comb begin
        o_val = XLEN'(ZeroWord);
        case (i_size)
            SizeByte: o_val = {{(XLEN-8){w_sign_b}}, i_buf[7:0]};
            SizeHalf: o_val = {{(XLEN-16){w_sign_h}}, i_buf[15:0]};
            default:  o_val = XLEN'(i_buf);
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: passes ALU results through and runs loads/stores byte-serially
// over the 8-bit memory-controller port. Option macro: MEM_MISALIGN_CHECK_EN.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned XLEN       = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  forward,
    input  logic [4:0]            rd_addr,
    input  logic [XLEN-1:0]       rd_val,
    input  logic [6:0]            ins_type,
    input  logic [2:0]            ins_details,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [XLEN-1:0]       mem_val,
    output logic                  mc_req,
    output logic                  mc_wr,
    output logic [ADDR_WIDTH-1:0] mc_addr,
    output logic [7:0]            mc_wdata,
    input  logic                  mc_ack,
    input  logic [7:0]            mc_rdata,
    output logic                  stall_req,
    output logic                  out_forward,
    output logic [4:0]            out_rd_addr,
    output logic [XLEN-1:0]       out_rd_val
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic                  misalign_err
`endif
);

    mem_state_e r_state;
    mem_state_e w_state_next;
    logic [2:0]  r_count;
    logic [2:0]  w_count_next;
    logic [31:0] r_buf;
    logic [31:0] w_buf_next;
    logic        r_misalign;
    logic        w_misalign_next;

    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_mem;
    mem_size_e       w_size;
    logic [2:0]      w_nbytes;
    logic            w_last_byte;
    logic            w_misaligned;
    logic [1:0]      w_byte_lane;
    logic [XLEN-1:0] w_load_val;

    assign w_is_load   = (ins_type == OpLoad);
    assign w_is_store  = (ins_type == OpStore);
    assign w_is_mem    = w_is_load | w_is_store;
    assign w_size      = decode_size(ins_details[1:0]);
    assign w_nbytes    = size_bytes(w_size);
    assign w_last_byte = (r_count == (w_nbytes - 3'd1));
    assign w_byte_lane = r_count[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(w_size, mem_addr[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    mem_access_stage_load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .i_buf      (r_buf),
        .i_size     (w_size),
        .i_unsigned (ins_details[F3UnsignedBit]),
        .o_val      (w_load_val)
    );

    // Next-state: everything holds while rdy_in is low, including ignoring mc_ack
    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_buf_next      = r_buf;
        w_misalign_next = r_misalign;
        if (rdy_in) begin
            unique case (r_state)
                StIdle: begin
                    if (w_is_mem) begin
                        w_count_next = 3'd0;
                        if (w_misaligned) begin
                            w_misalign_next = 1'b1;
                            w_state_next    = StDone;
                        end else begin
                            w_state_next = StXfer;
                        end
                    end
                end
                StXfer: begin
                    if (mc_ack) begin
                        if (w_is_load) begin
                            w_buf_next[{w_byte_lane, 3'b000} +: 8] = mc_rdata;
                        end
                        w_count_next = r_count + 3'd1;
                        if (w_last_byte) begin
                            w_state_next = StDone;
                        end
                    end
                end
                StDone: begin
                    w_misalign_next = 1'b0;
                    w_state_next    = StIdle;
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= StIdle;
            r_count    <= 3'd0;
            r_buf      <= ZeroWord;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_buf      <= w_buf_next;
            r_misalign <= w_misalign_next;
        end
    end

    // Outputs are held at zero for as long as reset is asserted
    always_comb begin
        mc_req      = 1'b0;
        mc_wr       = 1'b0;
        mc_addr     = '0;
        mc_wdata    = 8'h00;
        stall_req   = 1'b0;
        out_forward = 1'b0;
        out_rd_addr = 5'd0;
        out_rd_val  = '0;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_err = 1'b0;
`endif
        if (!rst_in) begin
            unique case (r_state)
                StIdle: begin
                    if (w_is_mem) begin
                        stall_req = 1'b1;
                    end else begin
                        out_forward = forward;
                        out_rd_addr = rd_addr;
                        out_rd_val  = rd_val;
                    end
                end
                StXfer: begin
                    stall_req = 1'b1;
                    mc_req    = rdy_in;
                    mc_wr     = w_is_store;
                    mc_addr   = mem_addr + ADDR_WIDTH'(r_count);
                    mc_wdata  = mem_val[{w_byte_lane, 3'b000} +: 8];
                end
                StDone: begin
                    if (w_is_load && !r_misalign) begin
                        out_forward = forward;
                        out_rd_addr = rd_addr;
                        out_rd_val  = w_load_val;
                    end
`ifdef MEM_MISALIGN_CHECK_EN
                    misalign_err = r_misalign;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: randomized loads/stores against a byte-array
// memory model with a delayed-ack controller. Optional macro: MEM_MISALIGN_CHECK_EN.
module tb_mem_access_stage;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        forward;
    logic [4:0]  rd_addr;
    logic [31:0] rd_val;
    logic [6:0]  ins_type;
    logic [2:0]  ins_details;
    logic [31:0] mem_addr;
    logic [31:0] mem_val;
    logic        mc_req;
    logic        mc_wr;
    logic [31:0] mc_addr;
    logic [7:0]  mc_wdata;
    logic        mc_ack;
    logic [7:0]  mc_rdata;
    logic        stall_req;
    logic        out_forward;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_rd_val;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    mem_access_stage #(
        .ADDR_WIDTH (32),
        .XLEN       (32)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .forward     (forward),
        .rd_addr     (rd_addr),
        .rd_val      (rd_val),
        .ins_type    (ins_type),
        .ins_details (ins_details),
        .mem_addr    (mem_addr),
        .mem_val     (mem_val),
        .mc_req      (mc_req),
        .mc_wr       (mc_wr),
        .mc_addr     (mc_addr),
        .mc_wdata    (mc_wdata),
        .mc_ack      (mc_ack),
        .mc_rdata    (mc_rdata),
        .stall_req   (stall_req),
        .out_forward (out_forward),
        .out_rd_addr (out_rd_addr),
        .out_rd_val  (out_rd_val)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  data;
    } bus_t;

    bus_t       bus_log[$];
    logic [7:0] mem [logic [31:0]];
    int         ack_delay;
    int         n_checks;
    int         n_fail;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Little-endian gather from the memory model, then numeric sign extension
    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
        longint raw;
        int     n;
        logic [31:0] ea;
        n   = size_of(f3);
        raw = 0;
        for (int i = 0; i < n; i++) begin
            ea  = addr + 32'(i);
            raw = raw + (longint'(mem_rd(ea)) << (8 * i));
        end
        if (!f3[2] && n < 4 && raw >= (longint'(1) << (8 * n - 1)))
            raw = raw - (longint'(1) << (8 * n));
        return raw[31:0];
    endfunction

    function automatic bit ref_misaligned(input logic [31:0] addr, input logic [2:0] f3);
        int n;
        n = size_of(f3);
        return (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
    endfunction

    // Memory controller: acks a pending request after ack_delay waiting cycles
    initial begin
        int   wcnt;
        bus_t ent;
        mc_ack   = 1'b0;
        mc_rdata = 8'h00;
        wcnt     = 0;
        forever begin
            @(posedge clk_in);
            #2;
            mc_ack   = 1'b0;
            mc_rdata = 8'h00;
            if (rst_in) begin
                wcnt = 0;
            end else if (mc_req) begin
                if (wcnt < ack_delay) begin
                    wcnt++;
                end else begin
                    wcnt     = 0;
                    mc_ack   = 1'b1;
                    ent.wr   = mc_wr;
                    ent.addr = mc_addr;
                    ent.data = mc_wdata;
                    bus_log.push_back(ent);
                    if (mc_wr) mem[mc_addr] = mc_wdata;
                    else       mc_rdata = mem_rd(mc_addr);
                end
            end
        end
    end

    task automatic set_ins(input logic fwd, input logic [4:0] rd, input logic [31:0] rv,
                           input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] val);
        forward     = fwd;
        rd_addr     = rd;
        rd_val      = rv;
        ins_type    = op;
        ins_details = f3;
        mem_addr    = addr;
        mem_val     = val;
    endtask

    task automatic set_nop();
        set_ins(1'b0, 5'd0, 32'd0, 7'b0010011, 3'd0, 32'd0, 32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the DONE cycle
    task automatic run_mem(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sval, input int delay, input int glitch_at,
                           input bit check_lat);
        int          n, nb, log0, stall_cyc, cyc, exp_bus;
        bit          done, mis;
        logic [31:0] exp_val, got_val, ea, sh;
        logic [4:0]  rd, got_rd;
        logic        fwd, got_fwd, got_req;
`ifdef MEM_MISALIGN_CHECK_EN
        logic        got_mis;
        got_mis = 1'bx;
`endif
        n   = size_of(f3);
        mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        mis = ref_misaligned(addr, f3);
`endif
        exp_val   = ref_load(addr, f3);
        rd        = 5'($urandom_range(1, 31));
        fwd       = st ? 1'($urandom) : 1'b1;
        ack_delay = delay;
        log0      = bus_log.size();
        set_ins(fwd, rd, $urandom, st ? OpStore : OpLoad, f3, addr, sval);
        stall_cyc = 0;
        cyc       = 0;
        done      = 1'b0;
        got_val   = 32'hxxxx_xxxx;
        got_rd    = 5'hxx;
        got_fwd   = 1'bx;
        got_req   = 1'bx;
        while (!done && cyc < 400) begin
            @(negedge clk_in);
            if (cyc == 0) check_eq("idle_fwd_suppressed", 32'(out_forward), 32'd0);
            if (stall_req) begin
                stall_cyc++;
            end else begin
                done    = 1'b1;
                got_val = out_rd_val;
                got_rd  = out_rd_addr;
                got_fwd = out_forward;
                got_req = mc_req;
`ifdef MEM_MISALIGN_CHECK_EN
                got_mis = misalign_err;
`endif
            end
            @(posedge clk_in);
            #1;
            cyc++;
            if (glitch_at > 0 && cyc == glitch_at)     rdy_in = 1'b0;
            if (glitch_at > 0 && cyc == glitch_at + 2) rdy_in = 1'b1;
        end
        rdy_in = 1'b1;
        check_eq("done_reached", 32'(done), 32'd1);
        if (st || mis) begin
            check_eq("done_fwd_off", 32'(got_fwd), 32'd0);
        end else begin
            check_eq("load_fwd", 32'(got_fwd), 32'd1);
            check_eq("load_rd", 32'(got_rd), 32'(rd));
            check_eq("load_val", got_val, exp_val);
        end
`ifdef MEM_MISALIGN_CHECK_EN
        check_eq("misalign_err", 32'(got_mis), 32'(mis));
`endif
        check_eq("done_mc_req", 32'(got_req), 32'd0);
        exp_bus = mis ? 0 : n;
        nb      = bus_log.size() - log0;
        check_eq("bus_count", 32'(nb), 32'(exp_bus));
        for (int i = 0; i < nb && i < 4; i++) begin
            ea = addr + 32'(i);
            sh = sval >> (8 * i);
            check_eq("bus_addr", bus_log[log0 + i].addr, ea);
            check_eq("bus_wr", 32'(bus_log[log0 + i].wr), 32'(st));
            if (st) check_eq("bus_wdata", 32'(bus_log[log0 + i].data), 32'(sh[7:0]));
        end
        if (check_lat) check_eq("stall_cycles", 32'(stall_cyc), mis ? 32'd1 : 32'(n + 1));
    endtask

    task automatic idle_cycles(input int k);
        int busy, log0;
        set_nop();
        busy = 0;
        log0 = bus_log.size();
        repeat (k) begin
            @(negedge clk_in);
            if (mc_req || stall_req || out_forward) busy++;
`ifdef MEM_MISALIGN_CHECK_EN
            if (misalign_err) busy++;
`endif
            @(posedge clk_in);
            #1;
        end
        check_eq("no_reissue", 32'(busy), 32'd0);
        check_eq("no_extra_bus", 32'(bus_log.size() - log0), 32'd0);
    endtask

    initial begin
        logic [6:0]  op;
        logic [31:0] rv, addr;
        logic [4:0]  rd;
        logic [2:0]  f3;
        bit          st;
        int          dly;
        n_checks  = 0;
        n_fail    = 0;
        ack_delay = 0;
        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        set_nop();
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        mem[32'h300] = 8'h80;
        mem[32'h400] = 8'h01; mem[32'h401] = 8'h80;

        // Reset holds every output at zero regardless of the inputs
        @(posedge clk_in); #1;
        set_ins(1'b1, 5'd3, 32'h55, OpLoad, 3'b010, 32'h100, 32'd0);
        @(negedge clk_in);
        check_eq("rst_stall", 32'(stall_req), 32'd0);
        check_eq("rst_mc_req", 32'(mc_req), 32'd0);
        @(posedge clk_in); #1;
        set_ins(1'b1, 5'd5, 32'h1234, 7'b0110011, 3'd0, 32'd0, 32'd0);
        @(negedge clk_in);
        check_eq("rst_fwd", 32'(out_forward), 32'd0);
        check_eq("rst_rd_val", out_rd_val, 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // ADD passthrough in the same cycle
        @(negedge clk_in);
        check_eq("add_fwd", 32'(out_forward), 32'd1);
        check_eq("add_rd", 32'(out_rd_addr), 32'd5);
        check_eq("add_val", out_rd_val, 32'h1234);
        check_eq("add_stall", 32'(stall_req), 32'd0);
        check_eq("add_mc_req", 32'(mc_req), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_in); #1;
            op = 7'($urandom);
            if (op == OpLoad || op == OpStore) op = 7'b0110011;
            rv = $urandom;
            rd = 5'($urandom);
            set_ins(1'($urandom), rd, rv, op, 3'($urandom), $urandom, $urandom);
            @(negedge clk_in);
            check_eq("pass_fwd", 32'(out_forward), 32'(forward));
            check_eq("pass_rd", 32'(out_rd_addr), 32'(rd));
            check_eq("pass_val", out_rd_val, rv);
            check_eq("pass_stall", 32'(stall_req), 32'd0);
        end
        @(posedge clk_in); #1;

        // Directed loads and stores
        run_mem(1'b0, 3'b010, 32'h100, 32'd0, 0, 0, 1'b1);
        run_mem(1'b0, 3'b000, 32'h300, 32'd0, 0, 0, 1'b1);
        run_mem(1'b0, 3'b100, 32'h300, 32'd0, 0, 0, 1'b1);
        run_mem(1'b0, 3'b101, 32'h400, 32'd0, 0, 0, 1'b1);
        run_mem(1'b1, 3'b001, 32'h2000, 32'hAABBCCDD, 0, 0, 1'b1);
        run_mem(1'b1, 3'b010, 32'h500, 32'hDEADBEEF, 1, 0, 1'b0);
        run_mem(1'b0, 3'b010, 32'h500, 32'd0, 0, 0, 1'b1);
        // Slow controller plus a rdy_in drop mid-transfer, then no re-issue
        run_mem(1'b0, 3'b010, 32'h100, 32'd0, 3, 3, 1'b0);
        idle_cycles(3);
        // Back-to-back loads
        run_mem(1'b0, 3'b001, 32'h100, 32'd0, 0, 0, 1'b1);
        run_mem(1'b0, 3'b000, 32'h401, 32'd0, 0, 0, 1'b1);
        idle_cycles(2);
`ifdef MEM_MISALIGN_CHECK_EN
        run_mem(1'b0, 3'b010, 32'h102, 32'd0, 0, 0, 1'b1);
        idle_cycles(2);
        run_mem(1'b1, 3'b001, 32'h2001, 32'h1234_5678, 0, 0, 1'b1);
        idle_cycles(1);
`else
        // Misaligned word that wraps past the top of the address space
        run_mem(1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0, 0, 0, 1'b1);
        run_mem(1'b1, 3'b010, 32'hFFFF_FFFD, 32'h0102_0304, 0, 0, 1'b1);
`endif

        for (int i = 0; i < 30; i++) begin
            st   = 1'($urandom);
            f3   = 3'($urandom);
            if (st) f3[2] = 1'b0;
            addr = $urandom;
`ifdef MEM_MISALIGN_CHECK_EN
            if (size_of(f3) == 2) addr[0] = 1'b0;
            if (size_of(f3) == 4) addr[1:0] = 2'b00;
`endif
            dly  = $urandom_range(0, 2);
            run_mem(st, f3, addr, $urandom, dly, 0, dly == 0);
        end

        // Reset in the middle of a slow SW transfer
        ack_delay = 3;
        set_ins(1'b1, 5'd9, 32'h1111, OpStore, 3'b010, 32'h600, 32'hCAFEF00D);
        repeat (6) begin
            @(posedge clk_in); #1;
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        check_eq("midrst_stall", 32'(stall_req), 32'd0);
        check_eq("midrst_mc_req", 32'(mc_req), 32'd0);
        check_eq("midrst_mc_wr", 32'(mc_wr), 32'd0);
        check_eq("midrst_mc_addr", mc_addr, 32'd0);
        check_eq("midrst_mc_wdata", 32'(mc_wdata), 32'd0);
        @(posedge clk_in); #1;
        set_nop();
        rst_in = 1'b0;
        @(negedge clk_in);
        check_eq("postrst_stall", 32'(stall_req), 32'd0);
        check_eq("postrst_mc_req", 32'(mc_req), 32'd0);
        @(posedge clk_in); #1;
        run_mem(1'b0, 3'b010, 32'h600, 32'd0, 0, 0, 1'b1);
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
